// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO burst reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int LEN_W_DEF     = 8;
    localparam int BUF_DEPTH_MIN = 3;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Purpose: small circular output buffer between FIFO read data and the byte stream.
// Latency: a pushed byte is visible on out_data the cycle after the push.
// Backpressure: holds head stable while out_ready is low; caller must never push when full.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_MIN,
    parameter int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic              do_pop;

    always_comb begin
        do_pop   = pop && (occ_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !do_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && do_pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: out_data is forced to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign occ       = occ_q;
    assign out_valid = (occ_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Purpose: pops burst_len bytes from a 1-cycle-latency FIFO and streams them out (optional FIFO_RD_TIMEOUT_EN abort).
// Latency: first fifo_rd_en the cycle after start is sampled; out_valid 2 cycles after the first accepted read.
// Backpressure: reads stop while buffered + in-flight bytes fill BUF_DEPTH; out_ready never reaches fifo_rd_en.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int BUF_DEPTH   = BUF_DEPTH_MIN,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic              fifo_rd_block,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  delivered_q, delivered_d;
    logic              inflight_q, inflight_d;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic              room, rd_acc, pop, drain_done;
    logic              timeout_hit, abort_path;

    fifo_rd_skid_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .OCC_W     (OCC_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Room is judged on registered occupancy plus the byte still in flight.
    assign room       = ({1'b0, occ} + (OCC_W+1)'(inflight_q)) < (OCC_W+1)'(BUF_DEPTH);
    assign fifo_rd_en = (state_q == READ) && !fifo_empty && (issued_q < len_q) && room;
    assign rd_acc     = fifo_rd_en && !fifo_rd_block;
    assign pop        = out_valid && out_ready;
    assign occ_next   = occ + OCC_W'(inflight_q) - OCC_W'(pop);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             aborted_q, aborted_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        aborted_d = aborted_q;
        if ((state_q != READ) || rd_acc) begin
            tmo_cnt_d = '0;
        end else if ((issued_q < len_q) && !inflight_q) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_hit = (state_q == READ) && (tmo_cnt_d == TMO_W'(TIMEOUT_CYC));
        if (state_q == IDLE) begin
            aborted_d = 1'b0;
        end else if (timeout_hit) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            aborted_q <= aborted_d;
        end
    end

    assign abort_path = aborted_q;
    assign err        = done && aborted_q;
`else
    assign timeout_hit = 1'b0;
    assign abort_path  = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = rd_acc;
        if (rd_acc) begin
            issued_d = issued_q + 1'b1;
        end
        if (pop) begin
            delivered_d = delivered_q + 1'b1;
        end
        // Leave DRAIN on the pop of the last byte so done follows it by one cycle.
        drain_done = !inflight_q && (occ_next == '0) &&
                     (abort_path || (delivered_d == len_q));
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = burst_len;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (timeout_hit || (issued_d == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule
